// File: rtl/rv_fetch_align.sv
// Instruction fetch/realign stage: byte pc -> aligned 32-bit or zero-extended 16-bit instruction.
// Optional one-word line buffer enabled by defining RV_FETCH_LINEBUF_EN.
module rv_fetch_align #(
  parameter int PC_LEN = 15
) (
  input  logic              clk,
  input  logic              c_rst_n,
  input  logic [31:0]       pc,
  input  logic              c_fetch_req,
  input  logic              c_flush,
  output logic [31:0]       instr,
  output logic              c_instr_valid,
  output logic              c_instr_fault,
  output logic [PC_LEN-3:0] imem_addr,
  output logic              c_imem_req,
  input  logic [31:0]       imem_rdata,
  input  logic              c_imem_ack
);
  localparam int AW = PC_LEN - 2;

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DONE} state_t;
  state_t state, state_d;

  logic [AW-1:0] w, w1;
  logic [31:0]   instr_q;
  logic          fault_q;
  logic [15:0]   held_hw;
  logic          hit, hit_cross;
  logic [31:0]   hit_word;
  logic          unused_pc;

  assign w         = pc[PC_LEN-1:2];
  assign w1        = w + AW'(1);
  assign unused_pc = ^pc[31:PC_LEN];

  function automatic logic [31:0] align_hw(input logic [31:0] word, input logic upper);
    if (upper)                  return {16'h0, word[31:16]};
    else if (word[1:0] == 2'b11) return word;
    else                        return {16'h0, word[15:0]};
  endfunction

`ifdef RV_FETCH_LINEBUF_EN
  logic          buf_valid;
  logic          fill_ok;
  logic [AW-1:0] buf_tag;
  logic [31:0]   buf_data;

  assign hit      = buf_valid && (buf_tag == w);
  assign hit_word = buf_data;

  // fill_ok tracks whether a flush hit the fetch in flight; such data is delivered but not cached.
  always_ff @(posedge clk) begin
    if (!c_rst_n) begin
      buf_valid <= 1'b0;
      fill_ok   <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else begin
      if (state == IDLE && c_fetch_req) fill_ok <= 1'b1;
      if (c_imem_ack && fill_ok && (state == FETCH0 || state == FETCH1)) begin
        buf_valid <= 1'b1;
        buf_tag   <= (state == FETCH1) ? w1 : w;
        buf_data  <= imem_rdata;
      end
      if (c_flush) begin
        buf_valid <= 1'b0;
        fill_ok   <= 1'b0;
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = c_flush;
  assign hit          = 1'b0;
  assign hit_word     = '0;
`endif

  // Hit on the upper half of a word that starts a 32-bit instruction: still needs word W+1.
  assign hit_cross = hit && pc[1] && (hit_word[17:16] == 2'b11);

  always_ff @(posedge clk) begin
    if (!c_rst_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (c_fetch_req) begin
          if (pc[0])          state_d = DONE;
          else if (hit_cross) state_d = FETCH1;
          else if (hit)       state_d = DONE;
          else                state_d = FETCH0;
        end
      end
      FETCH0: begin
        if (c_imem_ack) begin
          if (pc[1] && imem_rdata[17:16] == 2'b11) state_d = FETCH1;
          else                                     state_d = DONE;
        end
      end
      FETCH1:  if (c_imem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_imem_req    = 1'b0;
    imem_addr     = '0;
    c_instr_valid = 1'b0;
    c_instr_fault = 1'b0;
    case (state)
      FETCH0: begin
        c_imem_req = 1'b1;
        imem_addr  = w;
      end
      FETCH1: begin
        c_imem_req = 1'b1;
        imem_addr  = w1;
      end
      DONE: begin
        c_instr_valid = 1'b1;
        c_instr_fault = fault_q;
      end
      default: ;
    endcase
  end

  assign instr = instr_q;

  always_ff @(posedge clk) begin
    if (!c_rst_n) begin
      instr_q <= '0;
      fault_q <= 1'b0;
      held_hw <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_fetch_req) begin
            fault_q <= pc[0];
            if (pc[0])          instr_q <= '0;
            else if (hit_cross) held_hw <= hit_word[31:16];
            else if (hit)       instr_q <= align_hw(hit_word, pc[1]);
          end
        end
        FETCH0: begin
          if (c_imem_ack) begin
            if (pc[1] && imem_rdata[17:16] == 2'b11) held_hw <= imem_rdata[31:16];
            else                                     instr_q <= align_hw(imem_rdata, pc[1]);
          end
        end
        FETCH1: if (c_imem_ack) instr_q <= {imem_rdata[15:0], held_hw};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_fetch_align.sv
// Directed bench for rv_fetch_align: vector table plus flush and mid-fetch reset sequences.
module tb_rv_fetch_align;
  localparam int PC_LEN = 15;

  logic              clk = 1'b0;
  logic              c_rst_n = 1'b0;
  logic [31:0]       pc = '0;
  logic              c_fetch_req = 1'b0;
  logic              c_flush = 1'b0;
  logic [31:0]       instr;
  logic              c_instr_valid;
  logic              c_instr_fault;
  logic [PC_LEN-3:0] imem_addr;
  logic              c_imem_req;
  logic [31:0]       imem_rdata;
  logic              c_imem_ack;

  logic [31:0]       mem [0:8191];
  int unsigned       delay = 0;
  int unsigned       wcnt = 0;
  logic              ack_block = 1'b0;
  logic              ack_force = 1'b0;
  int                nacks = 0;
  int                viol = 0;
  logic [PC_LEN-3:0] last_addr = '0;
  int                n_checks = 0;
  int                n_pass = 0;

  rv_fetch_align #(.PC_LEN(PC_LEN)) dut (
    .clk(clk), .c_rst_n(c_rst_n), .pc(pc), .c_fetch_req(c_fetch_req), .c_flush(c_flush),
    .instr(instr), .c_instr_valid(c_instr_valid), .c_instr_fault(c_instr_fault),
    .imem_addr(imem_addr), .c_imem_req(c_imem_req), .imem_rdata(imem_rdata), .c_imem_ack(c_imem_ack)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];
  assign c_imem_ack = ack_force | (c_imem_req & ~ack_block & (wcnt >= delay));

  always @(posedge clk) begin
    if (!c_imem_req || c_imem_ack) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
    if (c_rst_n && c_imem_req && c_imem_ack) begin
      nacks     <= nacks + 1;
      last_addr <= imem_addr;
    end
    if (c_imem_req && c_instr_valid) viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " instr"}, instr, 32'h0);
    check({name, " valid"}, {31'h0, c_instr_valid}, 32'h0);
    check({name, " fault"}, {31'h0, c_instr_fault}, 32'h0);
    check({name, " req"},   {31'h0, c_imem_req}, 32'h0);
    check({name, " addr"},  {19'h0, imem_addr}, 32'h0);
  endtask

  task automatic run_req(input string name, input logic [31:0] p, input int unsigned d,
                         input logic [31:0] e_instr, input logic e_fault,
                         input int e_lat, input int e_nf, input int e_addr);
    int   lat;
    int   n0;
    logic got;
    delay = d;
    @(negedge clk);
    pc = p;
    c_fetch_req = 1'b1;
    n0 = nacks;
    @(posedge clk);
    #1 c_fetch_req = 1'b0;
    lat = -1;
    got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (c_instr_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(e_lat));
    check({name, " instr"}, instr, e_instr);
    check({name, " fault"}, {31'h0, c_instr_fault}, {31'h0, e_fault});
    check({name, " fetches"}, 32'(nacks - n0), 32'(e_nf));
    if (e_nf > 0) check({name, " last addr"}, {19'h0, last_addr}, 32'(e_addr));
    @(negedge clk);
    check({name, " pulse width"}, {31'h0, c_instr_valid}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int unsigned d;
    logic [31:0] ins;
    logic        f;
    int          lat;
    int          nf;
    int          lat_nb;
    int          nf_nb;
    int          addr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int vcount;
    int el, en;
    logic got;

    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[0]       = 32'h00500093;
    mem[1]       = 32'h00934585;
    mem[2]       = 32'h12340513;
    mem[5]       = 32'h40010001;
    mem[8]       = 32'h00000013;
    mem[13'h1FFF] = 32'h00B3AAAA;

    //             pc            d  instr         f     lat nf  latnb nfnb addr
    tbl[0]  = '{32'h0000_0000, 0, 32'h00500093, 1'b0, 2, 1, 2, 1, 0};
    tbl[1]  = '{32'h0000_0000, 0, 32'h00500093, 1'b0, 1, 0, 2, 1, 0};
    tbl[2]  = '{32'h0000_0004, 0, 32'h00004585, 1'b0, 2, 1, 2, 1, 1};
    tbl[3]  = '{32'h0000_0006, 0, 32'h05130093, 1'b0, 2, 1, 3, 2, 2};
    tbl[4]  = '{32'h0000_0003, 0, 32'h00000000, 1'b1, 1, 0, 1, 0, 0};
    tbl[5]  = '{32'h0000_0008, 0, 32'h12340513, 1'b0, 1, 0, 2, 1, 2};
    tbl[6]  = '{32'h0000_000A, 0, 32'h00001234, 1'b0, 1, 0, 2, 1, 2};
    tbl[7]  = '{32'h0000_7FFE, 0, 32'h009300B3, 1'b0, 3, 2, 3, 2, 0};
    tbl[8]  = '{32'h0000_0002, 0, 32'h00000050, 1'b0, 1, 0, 2, 1, 0};
    tbl[9]  = '{32'h0000_7FFC, 0, 32'h0000AAAA, 1'b0, 2, 1, 2, 1, 32'h1FFF};
    tbl[10] = '{32'h0000_7FFE, 0, 32'h009300B3, 1'b0, 2, 1, 3, 2, 0};
    tbl[11] = '{32'hFFFF_0004, 0, 32'h00004585, 1'b0, 2, 1, 2, 1, 1};
    tbl[12] = '{32'h0000_0014, 2, 32'h00000001, 1'b0, 4, 1, 4, 1, 5};
    tbl[13] = '{32'h0000_0006, 1, 32'h05130093, 1'b0, 5, 2, 5, 2, 2};
    tbl[14] = '{32'h0000_0016, 0, 32'h00004001, 1'b0, 2, 1, 2, 1, 5};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    c_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
`ifdef RV_FETCH_LINEBUF_EN
      el = tbl[i].lat;
      en = tbl[i].nf;
`else
      el = tbl[i].lat_nb;
      en = tbl[i].nf_nb;
`endif
      run_req($sformatf("v%0d", i), tbl[i].pc, tbl[i].d, tbl[i].ins, tbl[i].f, el, en, tbl[i].addr);
    end

    // Flush during a delayed FETCH0: data still delivered, but a re-request must miss.
    fork
      run_req("flush", 32'h20, 3, 32'h00000013, 1'b0, 5, 1, 8);
      begin
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        c_flush = 1'b1;
        @(negedge clk);
        c_flush = 1'b0;
      end
    join
    run_req("flush reissue", 32'h20, 3, 32'h00000013, 1'b0, 5, 1, 8);

    // Reset while in FETCH1; an ack after reset must be ignored.
    delay = 2;
    @(negedge clk);
    pc = 32'h6;
    c_fetch_req = 1'b1;
    @(posedge clk);
    #1 c_fetch_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (c_imem_req && imem_addr == 13'd2) got = 1'b1;
    end
    check("rst reach fetch1", {31'h0, got}, 32'h1);
    ack_block = 1'b1;
    c_rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst mid");
    c_rst_n = 1'b1;
    ack_block = 1'b0;
    ack_force = 1'b1;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) ack_force = 1'b0;
      if (c_instr_valid) vcount++;
    end
    check("rst late ack valid", 32'(vcount), 32'h0);
    check_idle_outputs("rst after");
    run_req("post rst", 32'h0, 0, 32'h00500093, 1'b0, 2, 1, 0);

    check("req during done", 32'(viol), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv_fetch_align.md
# rv_fetch_align

Instruction-fetch and realignment stage that sits directly upstream of the RV32IMC core's `instr` input. It turns the core's byte `pc` into 32-bit word reads on the instruction memory and returns one aligned instruction per request. Compressed instructions are returned as a 16-bit zero-extended word. A 32-bit instruction that starts at `pc[1]=1` is assembled from two consecutive memory words. A one-word line buffer avoids refetching the same word.

## Interface
Parameters:
- `PC_LEN`, default 15: number of significant `pc` bits (byte address); the word address is `pc[PC_LEN-1:2]`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `c_rst_n`  in  1  reset, synchronous, active-low
- `pc`  in  32  byte address from core; held stable from request until `c_instr_valid`
- `c_fetch_req`  in  1  core requests the instruction at `pc`; sampled only in IDLE
- `c_flush`  in  1  invalidates the line buffer (fence.i / redirect)
- `instr`  out  32  aligned instruction; `{16'h0, hw}` when compressed
- `c_instr_valid`  out  1  one-cycle pulse: `instr` valid
- `c_instr_fault`  out  1  one-cycle pulse with `c_instr_valid`: `pc[0]=1`
- `imem_addr`  out  PC_LEN-2  word address to instruction memory
- `c_imem_req`  out  1  memory read request; held until ack
- `imem_rdata`  in  32  read data; valid in the cycle `c_imem_ack=1`
- `c_imem_ack`  in  1  read complete; may assert in the same cycle as `c_imem_req`

## Operation
- W = `pc[PC_LEN-1:2]`. A halfword is 32-bit-start when `hw[1:0]==2'b11`; otherwise it is compressed.
- FSM states: IDLE, FETCH0, FETCH1, DONE.
- IDLE, `c_fetch_req=1`:
  - `pc[0]=1`: go to DONE with fault; `instr=0`; no memory access.
  - Buffer hit (valid and tag==W), and the instruction completes from the buffer: go to DONE.
  - Buffer hit with `pc[1]=1` and 32-bit start: the low half is taken from the buffer; go to FETCH1 with addr W+1.
  - Otherwise: go to FETCH0 with addr W.
- FETCH0: hold `c_imem_req=1` and `imem_addr=W` until ack. On ack, load the buffer (tag W) and select a half.
  - `pc[1]=0`: if 32-bit, `instr=rdata`; else `{16'h0, rdata[15:0]}`. Go to DONE.
  - `pc[1]=1`: if compressed, `instr={16'h0, rdata[31:16]}` and go to DONE. Else latch the low half and go to FETCH1.
- FETCH1: request word `(W+1) mod 2^(PC_LEN-2)`; the address wraps to 0. On ack, `instr={rdata[15:0], held_hw}`, the buffer is loaded with tag W+1, and the FSM goes to DONE.
- DONE: `c_instr_valid=1` for exactly one cycle, then IDLE. `instr` holds its value until the next DONE.
- `c_flush`:
  - Clears buffer valid in any state.
  - If asserted in the same cycle as an ack, or while a fetch is in flight, the returned data is still delivered to the core but is not written into the buffer.
- `pc` bits above `PC_LEN-1` are ignored.
- `c_fetch_req` outside IDLE is ignored.

## Timing
- Reset (`c_rst_n=0` at a rising edge) puts the block in IDLE with all outputs cleared: `instr=0`, `c_instr_valid=0`, `c_instr_fault=0`, `c_imem_req=0`, `imem_addr=0`, buffer invalid.
- Reset mid-fetch: `c_imem_req` drops on the next edge, and a later ack for the aborted read is ignored.
- Request accepted at edge T. With zero-wait memory (ack in the same cycle as req):
  - Fault or buffer hit: `c_instr_valid` in cycle T+1.
  - Aligned miss, or straddled compressed miss: valid in T+2.
  - Straddled 32-bit with both words missing: valid in T+3.
  - Straddled 32-bit with the low word hit: valid in T+2.
- Each ack wait cycle adds one cycle per fetch.
- `c_imem_req` is never asserted in IDLE or DONE. There is at most one outstanding read.
- Earliest back-to-back accept: the cycle after DONE.

## Configuration
- `RV_FETCH_LINEBUF_EN` defined: the one-word line buffer, hit detection and buffer fill are present, with hit latencies as above.
- Not defined:
  - The buffer logic is removed and every request fetches from memory.
  - A straddled 32-bit instruction always performs two fetches.
  - `c_flush` has no effect.
  - All other behaviour is identical.

## Test plan
- Reset, zero-wait memory, word 0 = `32'h00500093`, `pc=0`: `imem_addr=0` and `instr=32'h00500093` valid at T+2; the next request at `pc=0` hits, valid at T+1, with no `c_imem_req`.
- Word 1 = `32'h00934585`, `pc=4` then `pc=6`:
  - `pc=4` gives `instr=32'h00004585`.
  - `pc=6` (buffer hit, upper half `0x0093` is 32-bit start) fetches word 2 = `32'hXXXX0513` and returns `instr=32'h05130093`.
- `pc=3`: `c_instr_fault=1` and `c_instr_valid=1` at T+1, `instr=0`, no memory request.
- `PC_LEN=15`, `pc=32'h7FFE`, with the upper half of word `0x1FFF` a 32-bit start: the second fetch goes to `imem_addr=0`.
- Ack delayed 3 cycles, with `c_flush` pulsed during FETCH0: the instruction is still delivered; an immediate re-request of the same `pc` misses and refetches.
- `c_rst_n=0` during FETCH1 with an ack arriving after reset: FSM is IDLE, `c_instr_valid` never pulses, all outputs 0.
